// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer: next-PC selection, shared PC adder, fetch/flush/halt controls
// Optional feature macro: PC_RANGE_TRAP_EN (out-of-range branch or increment halts and sets sticky pc_fault)
module pc_sequencer #(
  parameter int PC_WIDTH  = 11,
  parameter int OFF_WIDTH = 32,
  parameter int RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_pc,
  input  logic [OFF_WIDTH-1:0] branch_offset,
  input  logic                 jump,
  input  logic [PC_WIDTH-1:0]  jump_target,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 fetch_valid,
  output logic                 flush,
  output logic                 halted,
  output logic                 pc_fault
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } state_e;

`ifdef PC_RANGE_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   fault_q, fault_d;
  logic                   fetch_valid_q;
  logic                   flush_q;
  logic                   halted_q;

  logic [OFF_WIDTH-1:0]   add_a;
  logic [OFF_WIDTH-1:0]   add_b;
  logic [OFF_WIDTH-1:0]   sum;
  logic                   sum_oor;

  // Shared adder: branch target (branch_pc + offset) or sequential increment (pc + 1), full width
  always_comb begin
    add_a   = {{(OFF_WIDTH-PC_WIDTH){1'b0}}, (branch_taken ? branch_pc : pc_q)};
    add_b   = branch_taken ? branch_offset : OFF_WIDTH'(1);
    sum     = add_a + add_b;
    // Any bit above the PC range set means the sum fell outside [0, 2^PC_WIDTH-1]
    sum_oor = |sum[OFF_WIDTH-1:PC_WIDTH];
  end

  // Next-state and next-PC selection; RUN priority is halt > branch > jump > stall > increment
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (branch_taken) begin
          if (TRAP_EN && sum_oor) begin
            state_d = HALT;
            fault_d = 1'b1;
          end else begin
            pc_d    = sum[PC_WIDTH-1:0];
            state_d = REDIRECT;
          end
        end else if (jump) begin
          pc_d    = jump_target;
          state_d = REDIRECT;
        end else if (!stall) begin
          if (TRAP_EN && sum_oor) begin
            state_d = HALT;
            fault_d = 1'b1;
          end else begin
            pc_d = sum[PC_WIDTH-1:0];
          end
        end
      end
      REDIRECT: begin
        // Redirect sources here come from the squashed wrong path
        state_d = halt_req ? HALT : RUN;
      end
      HALT: begin
        // A latched fault blocks resume until reset
        if (resume && !fault_q) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State, PC and registered output decode from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= PC_WIDTH'(RESET_PC);
      fault_q       <= 1'b0;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fault_q       <= fault_d;
      fetch_valid_q <= (state_d == RUN);
      flush_q       <= (state_d == REDIRECT);
      halted_q      <= (state_d == HALT);
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign flush       = flush_q;
  assign halted      = halted_q;

`ifdef PC_RANGE_TRAP_EN
  assign pc_fault = fault_q;
`else
  assign pc_fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard testbench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [10:0] branch_pc = '0;
  logic [31:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [10:0] jump_target = '0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [10:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        halted;
  logic        pc_fault;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        st;
    logic        br;
    logic [10:0] bpc;
    logic [31:0] boff;
    logic        jmp;
    logic [10:0] jt;
    logic        hr;
    logic        rs;
  } stim_t;

  stim_t       stim_q[$];
  logic [14:0] exp_q[$];
  logic [14:0] obs;
  logic [14:0] e;

  assign obs = {pc, fetch_valid, flush, halted, pc_fault};

  pc_sequencer #(.PC_WIDTH(11), .OFF_WIDTH(32), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .branch_offset(branch_offset), .jump(jump),
    .jump_target(jump_target), .halt_req(halt_req), .resume(resume),
    .pc(pc), .fetch_valid(fetch_valid), .flush(flush), .halted(halted),
    .pc_fault(pc_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t jmp_to(input logic [10:0] t);
    stim_t s;
    s = '0;
    s.jmp = 1'b1;
    s.jt = t;
    return s;
  endfunction

  function automatic stim_t br_to(input logic [10:0] b, input logic [31:0] o);
    stim_t s;
    s = '0;
    s.br = 1'b1;
    s.bpc = b;
    s.boff = o;
    return s;
  endfunction

  function automatic void push(input stim_t s, input logic [10:0] p, input logic fv,
                               input logic fl, input logic h, input logic f);
    stim_q.push_back(s);
    exp_q.push_back({p, fv, fl, h, f});
  endfunction

  task automatic apply(input stim_t s);
    stall = s.st;
    branch_taken = s.br;
    branch_pc = s.bpc;
    branch_offset = s.boff;
    jump = s.jmp;
    jump_target = s.jt;
    halt_req = s.hr;
    resume = s.rs;
  endtask

  task automatic do_reset();
    apply(idle());
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int n = 0;
    apply(idle());
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(15'd0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e)
      $display("FAIL reset_values got pc=%0d fv/fl/h/f=%b want pc=%0d fv/fl/h/f=%b", obs[14:4], obs[3:0], e[14:4], e[3:0]);
    if (obs !== e) failures++;
    rst_n = 1'b1;
    push(idle(), 11'd0, 1, 0, 0, 0);
    push(idle(), 11'd1, 1, 0, 0, 0);
    push(idle(), 11'd2, 1, 0, 0, 0);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL boot step%0d got pc=%0d fv/fl/h/f=%b want pc=%0d fv/fl/h/f=%b", n, obs[14:4], obs[3:0], e[14:4], e[3:0]);
      end
      n++;
    end
  endtask

  task automatic test_branch();
    int n = 0;
    stim_t s;
    push(jmp_to(11'd12), 11'd12, 0, 1, 0, 0);
    push(idle(), 11'd12, 1, 0, 0, 0);
    push(br_to(11'd10, -32'd4), 11'd6, 0, 1, 0, 0);
    push(idle(), 11'd6, 1, 0, 0, 0);
    push(idle(), 11'd7, 1, 0, 0, 0);
    s = br_to(11'd10, -32'd4);
    s.jmp = 1'b1;
    s.jt = 11'd100;
    push(s, 11'd6, 0, 1, 0, 0);
    push(idle(), 11'd6, 1, 0, 0, 0);
    push(jmp_to(11'd30), 11'd30, 0, 1, 0, 0);
    push(br_to(11'd10, -32'd4), 11'd30, 1, 0, 0, 0);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL branch step%0d got pc=%0d fv/fl/h/f=%b want pc=%0d fv/fl/h/f=%b", n, obs[14:4], obs[3:0], e[14:4], e[3:0]);
      end
      n++;
    end
  endtask

  task automatic test_stall();
    int n = 0;
    stim_t s;
    push(jmp_to(11'd5), 11'd5, 0, 1, 0, 0);
    push(idle(), 11'd5, 1, 0, 0, 0);
    s = idle();
    s.st = 1'b1;
    push(s, 11'd5, 1, 0, 0, 0);
    push(s, 11'd5, 1, 0, 0, 0);
    push(s, 11'd5, 1, 0, 0, 0);
    push(idle(), 11'd6, 1, 0, 0, 0);
    s = jmp_to(11'd40);
    s.st = 1'b1;
    push(s, 11'd40, 0, 1, 0, 0);
    push(idle(), 11'd40, 1, 0, 0, 0);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL stall step%0d got pc=%0d fv/fl/h/f=%b want pc=%0d fv/fl/h/f=%b", n, obs[14:4], obs[3:0], e[14:4], e[3:0]);
      end
      n++;
    end
  endtask

  task automatic test_halt();
    int n = 0;
    stim_t s;
    push(jmp_to(11'd20), 11'd20, 0, 1, 0, 0);
    push(idle(), 11'd20, 1, 0, 0, 0);
    s = idle();
    s.hr = 1'b1;
    push(s, 11'd20, 0, 0, 1, 0);
    push(br_to(11'd10, -32'd4), 11'd20, 0, 0, 1, 0);
    s = jmp_to(11'd7);
    s.st = 1'b1;
    push(s, 11'd20, 0, 0, 1, 0);
    s = idle();
    s.hr = 1'b1;
    s.rs = 1'b1;
    push(s, 11'd20, 1, 0, 0, 0);
    push(idle(), 11'd21, 1, 0, 0, 0);
    push(jmp_to(11'd50), 11'd50, 0, 1, 0, 0);
    s = idle();
    s.hr = 1'b1;
    push(s, 11'd50, 0, 0, 1, 0);
    s = idle();
    s.rs = 1'b1;
    push(s, 11'd50, 1, 0, 0, 0);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL halt step%0d got pc=%0d fv/fl/h/f=%b want pc=%0d fv/fl/h/f=%b", n, obs[14:4], obs[3:0], e[14:4], e[3:0]);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    push(br_to(11'd100, 32'd5), 11'd105, 0, 1, 0, 0);
    push(br_to(11'd100, -32'd50), 11'd105, 1, 0, 0, 0);
    push(br_to(11'd100, -32'd50), 11'd50, 0, 1, 0, 0);
    push(jmp_to(11'd9), 11'd50, 1, 0, 0, 0);
    push(jmp_to(11'd9), 11'd9, 0, 1, 0, 0);
    push(idle(), 11'd9, 1, 0, 0, 0);
    push(idle(), 11'd10, 1, 0, 0, 0);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL back_to_back step%0d got pc=%0d fv/fl/h/f=%b want pc=%0d fv/fl/h/f=%b", n, obs[14:4], obs[3:0], e[14:4], e[3:0]);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_redirect();
    int n = 0;
    apply(jmp_to(11'd77));
    @(posedge clk);
    #1;
    exp_q.push_back({11'd77, 4'b0100});
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL redirect_before_reset got pc=%0d fv/fl/h/f=%b want pc=%0d fv/fl/h/f=%b", obs[14:4], obs[3:0], e[14:4], e[3:0]);
    end
    apply(idle());
    rst_n = 1'b0;
    #1;
    exp_q.push_back(15'd0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL async_reset_mid_redirect got pc=%0d fv/fl/h/f=%b want pc=%0d fv/fl/h/f=%b", obs[14:4], obs[3:0], e[14:4], e[3:0]);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(idle(), 11'd0, 1, 0, 0, 0);
    push(idle(), 11'd1, 1, 0, 0, 0);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reboot step%0d got pc=%0d fv/fl/h/f=%b want pc=%0d fv/fl/h/f=%b", n, obs[14:4], obs[3:0], e[14:4], e[3:0]);
      end
      n++;
    end
  endtask

  task automatic test_range();
    int n = 0;
    stim_t s;
    s = idle();
    s.rs = 1'b1;
    do_reset();
    push(idle(), 11'd0, 1, 0, 0, 0);
    push(jmp_to(11'd2047), 11'd2047, 0, 1, 0, 0);
    push(idle(), 11'd2047, 1, 0, 0, 0);
`ifdef PC_RANGE_TRAP_EN
    push(idle(), 11'd2047, 0, 0, 1, 1);
    push(s, 11'd2047, 0, 0, 1, 1);
    push(s, 11'd2047, 0, 0, 1, 1);
`else
    push(idle(), 11'd0, 1, 0, 0, 0);
    push(idle(), 11'd1, 1, 0, 0, 0);
    push(br_to(11'd2040, 32'd20), 11'd12, 0, 1, 0, 0);
    push(idle(), 11'd12, 1, 0, 0, 0);
    push(br_to(11'd2, -32'd5), 11'd2045, 0, 1, 0, 0);
    push(idle(), 11'd2045, 1, 0, 0, 0);
`endif
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL range_inc step%0d got pc=%0d fv/fl/h/f=%b want pc=%0d fv/fl/h/f=%b", n, obs[14:4], obs[3:0], e[14:4], e[3:0]);
      end
      n++;
    end
    do_reset();
    push(idle(), 11'd0, 1, 0, 0, 0);
    push(idle(), 11'd1, 1, 0, 0, 0);
`ifdef PC_RANGE_TRAP_EN
    push(br_to(11'd2040, 32'd20), 11'd1, 0, 0, 1, 1);
    push(s, 11'd1, 0, 0, 1, 1);
`else
    push(br_to(11'd2040, 32'd20), 11'd12, 0, 1, 0, 0);
    push(s, 11'd12, 1, 0, 0, 0);
`endif
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL range_branch step%0d got pc=%0d fv/fl/h/f=%b want pc=%0d fv/fl/h/f=%b", n, obs[14:4], obs[3:0], e[14:4], e[3:0]);
      end
      n++;
    end
    do_reset();
    push(idle(), 11'd0, 1, 0, 0, 0);
    push(idle(), 11'd1, 1, 0, 0, 0);
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL range_reset_clear step%0d got pc=%0d fv/fl/h/f=%b want pc=%0d fv/fl/h/f=%b", n, obs[14:4], obs[3:0], e[14:4], e[3:0]);
      end
      n++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_branch();
    test_stall();
    test_halt();
    test_back_to_back();
    test_reset_mid_redirect();
    test_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
